// File: rtl/tile_pkg.sv
// Shared definitions for the double-buffered weight tile processing element.
package tile_pkg;

  // Default parameter values for tile_pe_db.
  localparam int DW_DEF    = 8;
  localparam int ACC_W_DEF = 20;
  localparam int ROW_W_DEF = 4;
  localparam int COL_W_DEF = 4;
  localparam int NW_DEF    = 4;

  // Swap controller states: IDLE has nothing outstanding, PEND holds a deferred commit.
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } swap_state_t;

endpackage

// File: rtl/pe_sat_add.sv
// Adds a 2*DW product to an ACC_W partial sum, then either wraps or clamps the result.
// Operands are sign- or zero-extended to ACC_W+1 bits, so the raw sum never overflows.
module pe_sat_add #(
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic [ACC_W-1:0] acc_in,
  input  logic [2*DW-1:0]  prod,
  input  logic             mode_signed,
  input  logic             sat_en,
  output logic [ACC_W-1:0] sum
);

  localparam int PAD = ACC_W + 1 - 2*DW;

  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] prod_ext;
  logic [ACC_W:0] raw;

  assign acc_ext  = {mode_signed & acc_in[ACC_W-1], acc_in};
  assign prod_ext = {{PAD{mode_signed & prod[2*DW-1]}}, prod};
  assign raw      = acc_ext + prod_ext;

  // Pick wrap or clamp. A signed result fits in ACC_W bits when the top two bits agree.
  always_comb begin
    sum = raw[ACC_W-1:0];
    if (sat_en) begin
      if (mode_signed) begin
        if (raw[ACC_W] != raw[ACC_W-1]) begin
          sum = raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
      end else if (raw[ACC_W]) begin
        sum = '1;
      end
    end
  end

endmodule

// File: rtl/tile_pe_db.sv
// Systolic tile PE with double-buffered weights. Configuration writes go to a shadow bank.
// The shadow bank is copied to the active bank only in a cycle with no valid activation.
module tile_pe_db
  import tile_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int ROW_W = ROW_W_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int NW    = NW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROW_W-1:0]       core_row,
  input  logic [COL_W-1:0]       core_col,
  input  logic                   cfg_valid,
  input  logic [ROW_W+COL_W-1:0] cfg_addr,
  input  logic [$clog2(NW)-1:0]  cfg_widx,
  input  logic [DW-1:0]          cfg_data,
  input  logic                   swap_req,
  output logic                   swap_done,
  input  logic                   mode_signed,
  input  logic                   sat_en,
  input  logic [$clog2(NW)-1:0]  w_sel,
  input  logic [DW-1:0]          x_in,
  input  logic                   x_vld_in,
  input  logic [ACC_W-1:0]       acc_in,
  output logic [DW-1:0]          x_out,
  output logic                   x_vld_out,
  output logic [ACC_W-1:0]       acc_out,
  output logic                   acc_vld_out,
  output logic                   swap_pend
);

  logic [DW-1:0] shadow [NW];
  logic [DW-1:0] active [NW];

  swap_state_t state, state_nxt;
  logic        do_copy;
  logic        cfg_hit;

  logic [DW-1:0]    w_cur;
  logic [2*DW-1:0]  prod_s;
  logic [2*DW-1:0]  prod_u;
  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] sum;

  assign cfg_hit = cfg_valid && (cfg_addr == {core_row, core_col});

  // Extending both operands to 2*DW first keeps the low 2*DW product bits exact for either mode.
  assign w_cur  = active[w_sel];
  assign prod_s = {{DW{w_cur[DW-1]}}, w_cur} * {{DW{x_in[DW-1]}}, x_in};
  assign prod_u = {{DW{1'b0}}, w_cur} * {{DW{1'b0}}, x_in};
  assign prod   = mode_signed ? prod_s : prod_u;

  pe_sat_add #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_add (
    .acc_in      (acc_in),
    .prod        (prod),
    .mode_signed (mode_signed),
    .sat_en      (sat_en),
    .sum         (sum)
  );

  // Swap controller next state: commit immediately when the MAC is idle, otherwise defer.
  always_comb begin
    state_nxt = state;
    do_copy   = 1'b0;
    case (state)
      IDLE: begin
        if (swap_req) begin
          if (x_vld_in) begin
            state_nxt = PEND;
          end else begin
            do_copy = 1'b1;
          end
        end
      end
      PEND: begin
        if (!x_vld_in) begin
          do_copy   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Swap state register and the one-cycle commit pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      swap_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      swap_done <= do_copy;
    end
  end

  assign swap_pend = (state == PEND);

  // Weight banks: writes touch only the shadow bank; a copy reads the pre-edge shadow values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (cfg_hit) begin
        shadow[cfg_widx] <= cfg_data;
      end
      if (do_copy) begin
        for (int i = 0; i < NW; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  // Forwarding registers and the accumulator, which holds whenever no activation is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_out       <= '0;
      x_vld_out   <= 1'b0;
      acc_out     <= '0;
      acc_vld_out <= 1'b0;
    end else begin
      x_out       <= x_in;
      x_vld_out   <= x_vld_in;
      acc_vld_out <= x_vld_in;
      if (x_vld_in) begin
        acc_out <= sum;
      end
    end
  end

endmodule

// File: tb/tb_tile_pe_db.sv
// Directed self-checking bench for tile_pe_db using hand-computed vectors.
module tb_tile_pe_db;

  logic        clk;
  logic        rst;
  logic [3:0]  core_row;
  logic [3:0]  core_col;
  logic        cfg_valid;
  logic [7:0]  cfg_addr;
  logic [1:0]  cfg_widx;
  logic [7:0]  cfg_data;
  logic        swap_req;
  logic        swap_done;
  logic        mode_signed;
  logic        sat_en;
  logic [1:0]  w_sel;
  logic [7:0]  x_in;
  logic        x_vld_in;
  logic [19:0] acc_in;
  logic [7:0]  x_out;
  logic        x_vld_out;
  logic [19:0] acc_out;
  logic        acc_vld_out;
  logic        swap_pend;

  int tests_run;
  int tests_failed;

  tile_pe_db dut (
    .clk         (clk),
    .rst         (rst),
    .core_row    (core_row),
    .core_col    (core_col),
    .cfg_valid   (cfg_valid),
    .cfg_addr    (cfg_addr),
    .cfg_widx    (cfg_widx),
    .cfg_data    (cfg_data),
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .mode_signed (mode_signed),
    .sat_en      (sat_en),
    .w_sel       (w_sel),
    .x_in        (x_in),
    .x_vld_in    (x_vld_in),
    .acc_in      (acc_in),
    .x_out       (x_out),
    .x_vld_out   (x_vld_out),
    .acc_out     (acc_out),
    .acc_vld_out (acc_vld_out),
    .swap_pend   (swap_pend)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one edge and settle just after it, so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vld, input logic [7:0] x, input logic [1:0] sel,
                               input logic [19:0] acc, input logic sgn, input logic sat,
                               input logic swp);
    x_vld_in    = vld;
    x_in        = x;
    w_sel       = sel;
    acc_in      = acc;
    mode_signed = sgn;
    sat_en      = sat;
    swap_req    = swp;
  endtask

  task automatic cfgWrite(input logic [7:0] addr, input logic [1:0] idx, input logic [7:0] data);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_widx  = idx;
    cfg_data  = data;
    applyStimulus(1'b0, 8'd0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b0);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic doSwap();
    applyStimulus(1'b0, 8'd0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b1);
    step();
    swap_req = 1'b0;
  endtask

  task automatic macCheck(input string tag, input logic [1:0] sel, input logic [7:0] x,
                          input logic [19:0] acc, input logic sgn, input logic sat,
                          input logic [19:0] expected);
    applyStimulus(1'b1, x, sel, acc, sgn, sat, 1'b0);
    step();
    checkOutput(tag, {12'd0, acc_out}, {12'd0, expected});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    core_row     = 4'h3;
    core_col     = 4'h5;
    cfg_valid    = 1'b0;
    cfg_addr     = 8'h00;
    cfg_widx     = 2'd0;
    cfg_data     = 8'h00;
    rst          = 1'b1;
    applyStimulus(1'b1, 8'hAA, 2'd0, 20'h12345, 1'b0, 1'b0, 1'b1);

    // Reset with a matching config write that must be dropped.
    cfg_valid = 1'b1;
    cfg_addr  = 8'h35;
    cfg_widx  = 2'd1;
    cfg_data  = 8'h77;
    step();
    step();
    checkOutput("rst_acc_out", {12'd0, acc_out}, 32'd0);
    checkOutput("rst_x_out", {24'd0, x_out}, 32'd0);
    checkOutput("rst_vld", {30'd0, x_vld_out, acc_vld_out}, 32'd0);
    checkOutput("rst_swap", {30'd0, swap_done, swap_pend}, 32'd0);
    cfg_valid = 1'b0;
    rst       = 1'b0;
    applyStimulus(1'b0, 8'd0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b0);
    step();

    // Write slot 2 = 5, swap while idle, then 3*5 + 10.
    cfgWrite(8'h35, 2'd2, 8'h05);
    doSwap();
    checkOutput("idle_swap_done", {31'd0, swap_done}, 32'd1);
    checkOutput("idle_swap_pend", {31'd0, swap_pend}, 32'd0);
    macCheck("mac_basic", 2'd2, 8'd3, 20'd10, 1'b0, 1'b0, 20'd25);
    checkOutput("mac_vld", {30'd0, x_vld_out, acc_vld_out}, 32'd3);
    checkOutput("mac_x_out", {24'd0, x_out}, 32'd3);
    checkOutput("swap_done_pulse", {31'd0, swap_done}, 32'd0);
    macCheck("rst_write_dropped", 2'd1, 8'd1, 20'd7, 1'b0, 1'b0, 20'd7);

    // Mismatched address leaves the shadow bank untouched.
    cfgWrite(8'h36, 2'd3, 8'h09);
    doSwap();
    macCheck("addr_mismatch", 2'd3, 8'd2, 20'd0, 1'b0, 1'b0, 20'd0);

    // Accumulator holds while no activation is valid; x still forwards.
    applyStimulus(1'b0, 8'd99, 2'd2, 20'd1000, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("acc_hold", {12'd0, acc_out}, 32'd0);
    checkOutput("hold_vld", {30'd0, x_vld_out, acc_vld_out}, 32'd0);
    checkOutput("hold_x_out", {24'd0, x_out}, 32'd99);

    // Deferred swap: three busy cycles with swap_req still use the old weight 5.
    cfgWrite(8'h35, 2'd2, 8'h0A);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'd1, 2'd2, 20'd0, 1'b0, 1'b0, 1'b1);
      step();
      checkOutput("pend_old_weight", {12'd0, acc_out}, 32'd5);
      checkOutput("pend_flag", {31'd0, swap_pend}, 32'd1);
      checkOutput("pend_no_done", {31'd0, swap_done}, 32'd0);
    end
    applyStimulus(1'b0, 8'd0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("pend_commit_done", {31'd0, swap_done}, 32'd1);
    checkOutput("pend_cleared", {31'd0, swap_pend}, 32'd0);
    step();
    checkOutput("pend_single_pulse", {31'd0, swap_done}, 32'd0);
    macCheck("pend_new_weight", 2'd2, 8'd1, 20'd0, 1'b0, 1'b0, 20'd10);

    // Write collides with a swap: the copy takes the old shadow value.
    cfgWrite(8'h35, 2'd0, 8'h11);
    cfg_valid = 1'b1;
    cfg_addr  = 8'h35;
    cfg_widx  = 2'd0;
    cfg_data  = 8'h22;
    applyStimulus(1'b0, 8'd0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b1);
    step();
    cfg_valid = 1'b0;
    checkOutput("collide_done", {31'd0, swap_done}, 32'd1);
    macCheck("collide_old", 2'd0, 8'd1, 20'd0, 1'b0, 1'b0, 20'h00011);
    doSwap();
    macCheck("collide_new", 2'd0, 8'd1, 20'd0, 1'b0, 1'b0, 20'h00022);

    // Load -128, 255 and 127 for the arithmetic corners.
    cfgWrite(8'h35, 2'd1, 8'h80);
    cfgWrite(8'h35, 2'd2, 8'hFF);
    cfgWrite(8'h35, 2'd3, 8'h7F);
    doSwap();
    // -128*127 + -524200 = -540456: clamps to -524288, wraps to 508120.
    macCheck("signed_sat_neg", 2'd1, 8'd127, 20'h80058, 1'b1, 1'b1, 20'h80000);
    macCheck("signed_wrap_neg", 2'd1, 8'd127, 20'h80058, 1'b1, 1'b0, 20'h7C0D8);
    // 127*127 + 524280 exceeds the positive limit.
    macCheck("signed_sat_pos", 2'd3, 8'd127, 20'h7FFF8, 1'b1, 1'b1, 20'h7FFFF);
    // -128 * -2 + 5 = 261, no clamp.
    macCheck("signed_plain", 2'd1, 8'hFE, 20'd5, 1'b1, 1'b1, 20'd261);
    // 255*255 + (2^20-1) wraps to 65024, or clamps to all ones.
    macCheck("unsigned_wrap", 2'd2, 8'd255, 20'hFFFFF, 1'b0, 1'b0, 20'd65024);
    macCheck("unsigned_sat", 2'd2, 8'd255, 20'hFFFFF, 1'b0, 1'b1, 20'hFFFFF);
    // The same 0x80 weight read as unsigned gives +256.
    macCheck("unsigned_0x80", 2'd1, 8'd2, 20'd0, 1'b0, 1'b0, 20'd256);

    // Reset while a swap is pending discards it.
    applyStimulus(1'b1, 8'd1, 2'd3, 20'd0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("pend_before_rst", {31'd0, swap_pend}, 32'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 8'd0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("rstpend_acc", {12'd0, acc_out}, 32'd0);
    checkOutput("rstpend_x", {24'd0, x_out}, 32'd0);
    checkOutput("rstpend_swap", {30'd0, swap_done, swap_pend}, 32'd0);
    rst = 1'b0;
    step();
    checkOutput("rstpend_no_done", {30'd0, swap_done, swap_pend}, 32'd0);
    macCheck("rstpend_active_clear", 2'd3, 8'd1, 20'd0, 1'b0, 1'b0, 20'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
